// File: rtl/ram_uart_pkg.sv
// rtl/ram_uart_pkg.sv - shared FSM encoding and UART framing constants for the RAM streamer
package ram_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // start bit + 8 data bits + stop bit
   localparam int   FRAME_BITS = 10;
   localparam logic UART_IDLE  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 UART transmitter owning baud counter, bit index and shift register
module uart_tx_serializer
   import ram_uart_pkg::*;
#(
   parameter int BAUD_DIV = 5208
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       TxD,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int               CNT_W    = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

   logic [CNT_W-1:0] baud_cnt;
   logic [3:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             serial_bit;
   logic             busy;

   // Bit index 0 is the start bit, 1..8 the data bits LSB first, 9 the stop bit.
   // The line level is registered so the start bit appears the cycle after tx_start.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         busy       <= 1'b0;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         serial_bit <= UART_IDLE;
      end else if (tx_start) begin
         busy       <= 1'b1;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_reg  <= tx_data;
         serial_bit <= 1'b0;
      end else if (busy) begin
         if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
               busy       <= 1'b0;
               bit_idx    <= '0;
               serial_bit <= UART_IDLE;
            end else begin
               bit_idx <= bit_idx + 4'd1;
               if (bit_idx < 4'd8) begin
                  serial_bit <= shift_reg[0];
                  shift_reg  <= {1'b0, shift_reg[7:1]};
               end else begin
                  serial_bit <= UART_IDLE;
               end
            end
         end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
         end
      end
   end

   assign TxD     = serial_bit;
   assign tx_busy = busy;
   // Last cycle of the stop bit
   assign tx_done = busy && (bit_idx == LAST_BIT) && (baud_cnt == CNT_LAST);

endmodule

// File: rtl/ram_uart_streamer.sv
// rtl/ram_uart_streamer.sv - walks message RAM and streams each character as a UART frame (option: STOP_ON_NUL_EN)
module ram_uart_streamer
   import ram_uart_pkg::*;
#(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 7,
   parameter int END_ADDR = 33,
   parameter int BAUD_DIV = 5208
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Start,
   input  logic [DATA_W-1:0] RamData,
   output logic [ADDR_W-1:0] Address,
   output logic              TxD,
   output logic              Busy,
   output logic              Done
);

   state_t            state, next_state;
   logic [ADDR_W-1:0] addr_next;
   logic              tx_start;
   logic              tx_busy;
   logic              tx_done;
   logic              ser_txd;
   logic [7:0]        tx_data;

   // RAM characters are narrower than a UART byte; upper bits go out as zero
   assign tx_data = 8'(RamData);

   uart_tx_serializer #(
      .BAUD_DIV (BAUD_DIV)
   ) u_ser (
      .Clock    (Clock),
      .Reset    (Reset),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .TxD      (ser_txd),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   // State and address registers; reset abandons any frame in flight
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state   <= ST_IDLE;
         Address <= '0;
      end else begin
         state   <= next_state;
         Address <= addr_next;
      end
   end

   // Sequencing: load one character, wait for its frame, advance or finish
   always_comb begin
      next_state = state;
      addr_next  = Address;
      tx_start   = 1'b0;
      case (state)
         ST_IDLE: begin
            addr_next = '0;
            if (Start) next_state = ST_LOAD;
         end
         ST_LOAD: begin
`ifdef STOP_ON_NUL_EN
            if (RamData == '0) begin
               next_state = ST_DONE;
            end else begin
               tx_start   = 1'b1;
               next_state = ST_SEND;
            end
`else
            tx_start   = 1'b1;
            next_state = ST_SEND;
`endif
         end
         ST_SEND: begin
            if (tx_done) begin
               if (Address == ADDR_W'(END_ADDR)) begin
                  next_state = ST_DONE;
               end else begin
                  addr_next  = Address + ADDR_W'(1);
                  next_state = ST_LOAD;
               end
            end
         end
         ST_DONE: begin
            addr_next  = '0;
            next_state = ST_IDLE;
         end
         default: begin
            addr_next  = '0;
            next_state = ST_IDLE;
         end
      endcase
   end

   assign TxD  = tx_busy ? ser_txd : UART_IDLE;
   assign Busy = (state != ST_IDLE);
   assign Done = (state == ST_DONE);

endmodule

// File: tb/tb_ram_uart_streamer.sv
// tb/tb_ram_uart_streamer.sv - directed and randomized self-checking bench for ram_uart_streamer
module tb_ram_uart_streamer;

   localparam int BAUD_DIV = 4;
   localparam int END_ADDR = 33;
   localparam int NCHARS   = END_ADDR + 1;
   localparam int CHAR_CYC = 1 + 10 * BAUD_DIV;
   localparam int RUN_MAX  = NCHARS * CHAR_CYC + 100;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       Start;
   logic [6:0] RamData;
   logic [5:0] Address;
   logic       TxD;
   logic       Busy;
   logic       Done;

   logic [6:0] ram [0:39];
   logic [7:0] exp_q [$];
   logic [7:0] rx_q [$];
   logic       stop_q [$];

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   int          done_cnt = 0;
   int unsigned load_cyc = 0;
   int unsigned done_cyc = 0;
   logic        busy_prev = 1'b0;

   string msg = "ECE333 Fall 2015 Digital Systems\n\r";

   ram_uart_streamer #(
      .ADDR_W   (6),
      .DATA_W   (7),
      .END_ADDR (END_ADDR),
      .BAUD_DIV (BAUD_DIV)
   ) dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .Start   (Start),
      .RamData (RamData),
      .Address (Address),
      .TxD     (TxD),
      .Busy    (Busy),
      .Done    (Done)
   );

   always #5 Clock = ~Clock;

   assign RamData = ram[Address];

   always @(posedge Clock) cyc <= cyc + 1;

   // Done pulse counter and run-start timestamp
   always @(negedge Clock) begin
      if (Done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (Busy === 1'b1 && busy_prev == 1'b0) load_cyc = cyc;
      busy_prev = Busy;
   end

   // Independent UART receiver: sample each bit mid-period after a falling edge
   initial begin : rx_mon
      logic [7:0] b;
      b = '0;
      forever begin
         @(negedge Clock);
         if (TxD === 1'b0) begin
            repeat (BAUD_DIV / 2) @(negedge Clock);
            for (int i = 0; i < 8; i++) begin
               repeat (BAUD_DIV) @(negedge Clock);
               b[i] = TxD;
            end
            repeat (BAUD_DIV) @(negedge Clock);
            stop_q.push_back(TxD);
            rx_q.push_back(b);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_msg();
      byte c;
      for (int i = 0; i < 40; i++) begin
         c = (i < NCHARS) ? msg[i] : 8'h00;
         ram[i] = c[6:0];
      end
   endtask

   task automatic set_exp_from_ram(input int count);
      exp_q.delete();
      for (int i = 0; i < count; i++) exp_q.push_back({1'b0, ram[i]});
   endtask

   task automatic pulse_start();
      @(negedge Clock);
      Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge Clock);
         #1;
         if (Done === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_addr(input logic [5:0] target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge Clock);
         #1;
         if (Address === target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic compare_frames(input string tag, input int base);
      int n;
      n = rx_q.size() - base;
      check($sformatf("%s_frame_count", tag), n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         check($sformatf("%s_char%0d", tag, i), rx_q[base + i], exp_q[i]);
         check($sformatf("%s_stop%0d", tag, i), stop_q[base + i], 1);
      end
   endtask

   initial begin : main
      bit         ok;
      int         base;
      int         dbase;
      int         k;
      logic [9:0] frame;
      logic [6:0] v;

      Reset = 1'b1;
      Start = 1'b0;
      load_msg();

      // Reset state
      repeat (2) @(posedge Clock);
      #1;
      check("rst_txd", TxD, 1);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      check("rst_addr", Address, 0);
      Reset = 1'b0;

      // Reset in the middle of the third character
      pulse_start();
      wait_addr(6'd2, 4 * CHAR_CYC, ok);
      check("t1_reach_char3", ok, 1);
      repeat ($urandom_range(3, 35)) @(posedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      check("t1_txd", TxD, 1);
      check("t1_busy", Busy, 0);
      check("t1_addr", Address, 0);
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      dbase = done_cnt;
      repeat (100) @(posedge Clock);
      #1;
      check("t1_no_done", done_cnt - dbase, 0);
      check("t1_idle_busy", Busy, 0);

      // First frame bit timing, then the whole message
      base  = rx_q.size();
      dbase = done_cnt;
      frame = {1'b1, 1'b0, ram[0], 1'b0};
      pulse_start();
      check("t2_busy", Busy, 1);
      check("t2_load_txd", TxD, 1);
      for (int i = 0; i < 10 * BAUD_DIV; i++) begin
         @(posedge Clock);
         #1;
         check($sformatf("t2_bit%0d_cyc%0d", i / BAUD_DIV, i % BAUD_DIV), TxD, frame[i / BAUD_DIV]);
      end
      wait_done(RUN_MAX, ok);
      check("t3_done_seen", ok, 1);
      @(posedge Clock);
      #1;
      check("t3_addr_end", Address, 0);
      check("t3_busy_end", Busy, 0);
      repeat (5) @(posedge Clock);
      check("t3_done_pulses", done_cnt - dbase, 1);
      check("t3_latency", done_cyc - load_cyc, NCHARS * CHAR_CYC);
      set_exp_from_ram(NCHARS);
      compare_frames("t3", base);

      // Start re-asserted during the tenth character is ignored
      base  = rx_q.size();
      dbase = done_cnt;
      pulse_start();
      wait_addr(6'd9, 11 * CHAR_CYC, ok);
      check("t4_reach_char10", ok, 1);
      repeat ($urandom_range(2, 30)) @(posedge Clock);
      pulse_start();
      wait_done(RUN_MAX, ok);
      check("t4_done_seen", ok, 1);
      repeat (5) @(posedge Clock);
      check("t4_done_pulses", done_cnt - dbase, 1);
      compare_frames("t4", base);

      // NUL at address 5
      base  = rx_q.size();
      dbase = done_cnt;
      ram[5] = 7'h00;
`ifdef STOP_ON_NUL_EN
      set_exp_from_ram(5);
`else
      set_exp_from_ram(NCHARS);
`endif
      pulse_start();
      wait_done(RUN_MAX, ok);
      check("t5_done_seen", ok, 1);
      compare_frames("t5", base);
      load_msg();

      // Start coincident with Done is ignored; a second Start two cycles later runs
      Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      check("t6_ignored_busy", Busy, 0);
      @(posedge Clock);
      #1;
      base  = rx_q.size();
      Start = 1'b1;
      @(posedge Clock);
      #1;
      Start = 1'b0;
      check("t6_restart_busy", Busy, 1);
      wait_done(RUN_MAX, ok);
      check("t6_done_seen", ok, 1);
      repeat (5) @(posedge Clock);
      check("t5_t6_done_pulses", done_cnt - dbase, 2);
      set_exp_from_ram(NCHARS);
      compare_frames("t6", base);

      // Random contents, rewritten mid-stream: the in-flight character keeps its old value
      for (int i = 0; i < NCHARS; i++) ram[i] = 7'($urandom_range(1, 127));
      set_exp_from_ram(NCHARS);
      base  = rx_q.size();
      dbase = done_cnt;
      k     = $urandom_range(3, 20);
      pulse_start();
      wait_addr(6'(k), (k + 2) * CHAR_CYC, ok);
      check("t7_reach_k", ok, 1);
      repeat (2) @(posedge Clock);
      #1;
      for (int j = k; j < NCHARS; j++) begin
         v = 7'($urandom_range(1, 127));
         ram[j] = v;
         if (j > k) exp_q[j] = {1'b0, v};
      end
      wait_done(RUN_MAX, ok);
      check("t7_done_seen", ok, 1);
      repeat (5) @(posedge Clock);
      check("t7_done_pulses", done_cnt - dbase, 1);
      compare_frames("t7", base);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
